fpu_thread_arb: RTL

FPU_THREAD_ARB -- requirements
Module: fpu_thread_arb

---
 rtl/fpu_mt_pkg.sv | 17 +
 rtl/rr_pick.sv | 32 +++
 rtl/fpu_thread_arb.sv | 98 +++++++++
 3 files changed

// File: rtl/fpu_mt_pkg.sv
// Shared types/constants for the multithreaded FPU front end: defaults, id width helper, stage tag.
// Pure declarations; no timing or flow control of its own.
package fpu_mt_pkg;
    localparam int NT_DEF = 4;
    localparam int NS_DEF = 4;
    // Tag id is sized for the largest legal thread count (8) so the type is parameter-free.
    localparam int ID_W   = 3;

    function automatic int tw_of(input int nt);
        return (nt <= 2) ? 1 : $clog2(nt);
    endfunction

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational thread picker: round-robin from ptr+1 (mode=1) or lowest index (mode=0).
// Zero latency; no requester gives sel=0, gnt=0, any=0.
module rr_pick
    import fpu_mt_pkg::*;
#(
    parameter int NT = NT_DEF,
    parameter int TW = tw_of(NT)
) (
    input  logic [NT-1:0] req,
    input  logic [TW-1:0] ptr,
    input  logic          mode,
    output logic [TW-1:0] sel,
    output logic [NT-1:0] gnt,
    output logic          any
);
    int w_start;
    int w_idx;

    // Walk the scan order backwards so the earliest requester in scan order is written last.
    always_comb begin
        sel     = '0;
        any     = |req;
        w_start = mode ? (int'(ptr) + 1) : 0;
        w_idx   = 0;
        for (int i = NT - 1; i >= 0; i--) begin
            w_idx = w_start + i;
            if (w_idx >= NT) w_idx = w_idx - NT;
            if (req[w_idx]) sel = TW'(w_idx);
        end
        gnt = any ? (NT'(1) << sel) : '0;
    end
endmodule

// File: rtl/fpu_thread_arb.sv
// Arbitrates NT threads onto one FPU in ID and tags each issued op through NS stages to demux write-enables.
// Grant/mux are combinational; tag reaches E1 one enabled cycle later, WB after NS; e=0 freezes all state, fstall blocks issue.
module fpu_thread_arb
    import fpu_mt_pkg::*;
#(
    parameter int NT = NT_DEF,
    parameter int NS = NS_DEF,
    parameter int RR = 1
) (
    input  logic                clk,
    input  logic                clrn,
    input  logic                e,
    input  logic [NT-1:0]       req,
    input  logic [NT*32-1:0]    dfa_in,
    input  logic [NT*32-1:0]    dfb_in,
    input  logic [NT*5-1:0]     fd_in,
    input  logic [NT*3-1:0]     fc_in,
    input  logic [NT-1:0]       wf_in,
    input  logic                fstall,
    input  logic [NS-1:0]       stg_w,
    output logic [31:0]         dfa,
    output logic [31:0]         dfb,
    output logic [4:0]          fd,
    output logic [2:0]          fc,
    output logic                wf,
    output logic [tw_of(NT)-1:0] sel,
    output logic [NT-1:0]       gnt,
    output logic [NT-1:0]       st,
    output logic [NT-1:0]       stall_t,
    output logic [NS*NT-1:0]    stg_w_t,
    output logic [NS-1:0]       stg_v
);
    localparam int TW = tw_of(NT);

    logic [TW-1:0] r_ptr;
    tag_t          r_tag [NS];
    logic [TW-1:0] w_sel;
    logic [NT-1:0] w_gnt;
    logic          w_any;
    logic          w_mode;

    assign w_mode = (RR != 0);

    rr_pick #(.NT(NT), .TW(TW)) u_pick (
        .req  (req),
        .ptr  (r_ptr),
        .mode (w_mode),
        .sel  (w_sel),
        .gnt  (w_gnt),
        .any  (w_any)
    );

    // ptr only ever loads a picker result, which is always < NT, so wrap is implicit.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_ptr <= TW'(NT - 1);
            for (int s = 0; s < NS; s++) r_tag[s] <= '0;
        end else if (e) begin
            if (w_any && !fstall) r_ptr <= w_sel;
            r_tag[0] <= {w_any & ~fstall, ID_W'(w_sel)};
            for (int s = 1; s < NS; s++) r_tag[s] <= r_tag[s-1];
        end
    end

    always_comb begin
        dfa = dfa_in[31:0];
        dfb = dfb_in[31:0];
        fd  = fd_in[4:0];
        fc  = fc_in[2:0];
        wf  = wf_in[0];
        for (int t = 1; t < NT; t++) begin
            if (w_sel == TW'(t)) begin
                dfa = dfa_in[32*t +: 32];
                dfb = dfb_in[32*t +: 32];
                fd  = fd_in[5*t +: 5];
                fc  = fc_in[3*t +: 3];
                wf  = wf_in[t];
            end
        end
    end

    assign sel     = w_sel;
    assign gnt     = w_gnt;
    assign st      = req & ~w_gnt;
    assign stall_t = fstall ? w_gnt : '0;

    // Routing follows the tag id even when invalid, so post-reset writes land on thread 0.
    always_comb begin
        stg_w_t = '0;
        stg_v   = '0;
        for (int s = 0; s < NS; s++) begin
            stg_v[s] = r_tag[s].valid;
            for (int t = 0; t < NT; t++) begin
                stg_w_t[s*NT + t] = stg_w[s] & (r_tag[s].id == ID_W'(t));
            end
        end
    end
endmodule
